latch_sr: RTL and testbench
===========================

Name: latch_sr

Overview:
- Clocked, reset-dominant set/reset storage element for the microwave controller magnetron path.
- Holds the magnetron-enable state: set turns it on, reset turns it off, and no request holds the last value.
- Built as a parameterised bank of WIDTH independent SR cells.
- Each cell has conflict detection, a change pulse and a complemented output.

Parameters:
- WIDTH, 1, number of independent SR cells (bit i of every vector belongs to cell i).
- RESET_DOMINANT, 1, resolution when set and reset are both high: 1 forces Q to 0, 0 forces Q to 1.
- INIT, 0, per-bit value loaded into Q on rst (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- set  input  WIDTH  per-cell set request, sampled on the clk rising edge.
- reset  input  WIDTH  per-cell clear request, sampled on the clk rising edge.
- Q  output  WIDTH  stored state, registered.
- Q_n  output  WIDTH  bitwise complement of Q, always ~Q (combinational from the Q register).
- conflict  output  WIDTH  registered flag, high for one cycle after a cycle in which set and reset were both high for that bit.
- changed  output  WIDTH  registered one-cycle pulse, high in the cycle after a Q bit toggled.

Behaviour:
- rst high (asynchronous, at any time): Q=INIT, conflict=0, changed=0, and Q_n=~INIT immediately.
- rst is released synchronously in the system; state updates resume on the first rising clk edge with rst low.
- Per-bit next-state on each rising clk edge when rst is low:
  - set=0, reset=0: hold Q.
  - set=1, reset=0: Q<=1.
  - set=0, reset=1: Q<=0.
  - set=1, reset=1: Q<=0 if RESET_DOMINANT=1, else Q<=1.
- Latency: one clock. Q reflects the edge-sampled inputs right after that edge; there is no combinational path from set/reset to any output.
- conflict[i]<=set[i]&reset[i] every edge, regardless of the current Q.
- changed[i]<=1 only when the next Q differs from the current Q. Set while already 1, or reset while already 0, gives changed=0.
- Bits are fully independent; there is no cross-bit interaction.
- Inputs are assumed synchronous to clk; no internal synchroniser.
- rst asserted while set is high: rst wins, and Q stays INIT until the first edge after release.
- Inputs held constant across many cycles: Q stable, changed=0 after the first edge, and conflict stays high while both inputs are held high.
- No latches or combinational loops; every storage element is an edge-triggered flop with async clear/preset.

Decomposition:
- Shared package, latch_sr_pkg: the SR request encoding constants SR_HOLD=2'b00, SR_SET=2'b10, SR_CLR=2'b01, SR_BOTH=2'b11, indexed as {set,reset}, plus a next_state(q, req, reset_dominant) function.
- Sub-module latch_sr_cell: one bit of Q, conflict and changed, instantiated WIDTH times via generate.
- The top level handles only parameter fan-out and the Q_n assignment.

Test Plan:
- rst=1 with set=1: Q=0, Q_n=1, conflict=0, changed=0, all asynchronously, before any clock edge (INIT=0).
- Release rst, then clk edges with {set,reset} = 01, 00, 10, 01: Q = 0, 0, 1, 0 after each edge; changed=1 only after the 10 and final 01 edges.
- {set,reset}=11 with RESET_DOMINANT=1 from Q=1: Q=0, conflict=1, changed=1. Repeat with RESET_DOMINANT=0 from Q=0: Q=1, conflict=1.
- Hold: after Q=1, apply 00 for 5 edges: Q=1 throughout, changed=0, conflict=0.
- Mid-operation reset: Q=1, assert rst between edges: Q drops to 0 at once without waiting for clk; the edge after release with set=1 gives Q=1.
- WIDTH=4, INIT=4'b1010, set=4'b0001, reset=4'b1000, one edge: Q=4'b0011, changed=4'b1001, and every bit checked for Q_n==~Q.

Source files
------------

// File: rtl/latch_sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : latch_sr_pkg
//  Purpose  : Request encoding and next-state resolution shared by the
//             magnetron-enable SR storage bank.
//  Revision : 1.0 - initial release
// ============================================================================
package latch_sr_pkg;

    // Request encodings, indexed as {set, reset}
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;
    localparam logic [1:0] SR_BOTH = 2'b11;

    // Next value of one cell. A simultaneous set and reset resolves to
    // the complement of the dominance selector: reset-dominant gives 0.
    function automatic logic next_state(
        input logic       q,
        input logic [1:0] req,
        input logic       reset_dominant
    );
        logic r_nxt;
        r_nxt = q;
        case (req)
            SR_HOLD: r_nxt = q;
            SR_SET:  r_nxt = 1'b1;
            SR_CLR:  r_nxt = 1'b0;
            SR_BOTH: r_nxt = ~reset_dominant;
            default: r_nxt = q;
        endcase
        return r_nxt;
    endfunction

endpackage : latch_sr_pkg
`default_nettype wire

// File: rtl/latch_sr_cell.sv
`default_nettype none
// ============================================================================
//  Module   : latch_sr_cell
//  Purpose  : One clocked SR storage bit with conflict flag and change pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module latch_sr_cell
    import latch_sr_pkg::*;
#(
    parameter bit RESET_DOMINANT = 1'b1,
    parameter bit INIT           = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic reset,
    output logic q,
    output logic conflict,
    output logic changed
);

    logic r_q;
    logic r_conflict;
    logic r_changed;
    logic w_q_next;

    // Resolve this edge's request against the currently stored value
    assign w_q_next = next_state(r_q, {set, reset}, RESET_DOMINANT);

    // State, conflict flag and change pulse all register on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= INIT;
            r_conflict <= 1'b0;
            r_changed  <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_conflict <= set & reset;
            r_changed  <= w_q_next ^ r_q;
        end
    end

    assign q        = r_q;
    assign conflict = r_conflict;
    assign changed  = r_changed;

endmodule : latch_sr_cell
`default_nettype wire

// File: rtl/latch_sr.sv
`default_nettype none
// ============================================================================
//  Module   : latch_sr
//  Purpose  : Bank of WIDTH independent clocked SR cells holding the
//             magnetron-enable state, with complemented output.
//  Revision : 1.0 - initial release
// ============================================================================
module latch_sr
    import latch_sr_pkg::*;
#(
    parameter int               WIDTH          = 1,
    parameter bit               RESET_DOMINANT = 1'b1,
    parameter logic [WIDTH-1:0] INIT           = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] reset,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] conflict,
    output logic [WIDTH-1:0] changed
);

    // One cell per bit; bits never interact
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            latch_sr_cell #(
                .RESET_DOMINANT (RESET_DOMINANT),
                .INIT           (INIT[gi])
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .set      (set[gi]),
                .reset    (reset[gi]),
                .q        (Q[gi]),
                .conflict (conflict[gi]),
                .changed  (changed[gi])
            );
        end
    endgenerate

    // Complement follows the register directly, including during reset
    assign Q_n = ~Q;

endmodule : latch_sr
`default_nettype wire

// File: tb/tb_latch_sr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_sr
//  Purpose  : Directed self-checking bench for latch_sr.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_latch_sr;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // dut_a: reset-dominant single cell
    logic       a_set = 1'b0, a_reset = 1'b0;
    logic       a_q, a_qn, a_conf, a_chg;
    // dut_b: set-dominant single cell
    logic       b_set = 1'b0, b_reset = 1'b0;
    logic       b_q, b_qn, b_conf, b_chg;
    // dut_c: four cells with non-zero INIT
    logic [3:0] c_set = 4'b0, c_reset = 4'b0;
    logic [3:0] c_q, c_qn, c_conf, c_chg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    latch_sr #(.WIDTH(1), .RESET_DOMINANT(1'b1), .INIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .set(a_set), .reset(a_reset),
        .Q(a_q), .Q_n(a_qn), .conflict(a_conf), .changed(a_chg)
    );

    latch_sr #(.WIDTH(1), .RESET_DOMINANT(1'b0), .INIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .set(b_set), .reset(b_reset),
        .Q(b_q), .Q_n(b_qn), .conflict(b_conf), .changed(b_chg)
    );

    latch_sr #(.WIDTH(4), .RESET_DOMINANT(1'b1), .INIT(4'b1010)) dut_c (
        .clk(clk), .rst(rst), .set(c_set), .reset(c_reset),
        .Q(c_q), .Q_n(c_qn), .conflict(c_conf), .changed(c_chg)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check Q, Q_n, conflict, changed of dut_a together
    task automatic check_a(input string tag, input logic q, input logic conf, input logic chg);
        check({tag, ".Q"},        {3'b0, a_q},    {3'b0, q});
        check({tag, ".Q_n"},      {3'b0, a_qn},   {3'b0, ~q});
        check({tag, ".conflict"}, {3'b0, a_conf}, {3'b0, conf});
        check({tag, ".changed"},  {3'b0, a_chg},  {3'b0, chg});
    endtask

    initial begin
        // Asynchronous reset with set high, before any clock edge
        a_set = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_a("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst_c.Q",   c_q,   4'b1010);
        check("async_rst_c.Q_n", c_qn,  4'b0101);

        // Edge while rst is still high: rst wins over set
        step();
        check_a("rst_over_set", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // {set,reset} = 01, 00, 10, 01
        a_set = 1'b0; a_reset = 1'b1; step();
        check_a("seq01", 1'b0, 1'b0, 1'b0);
        a_set = 1'b0; a_reset = 1'b0; step();
        check_a("seq00", 1'b0, 1'b0, 1'b0);
        a_set = 1'b1; a_reset = 1'b0; step();
        check_a("seq10", 1'b1, 1'b0, 1'b1);
        a_set = 1'b0; a_reset = 1'b1; step();
        check_a("seq01b", 1'b0, 1'b0, 1'b1);

        // Set again, then both high on dut_a (reset-dominant, from Q=1)
        // while dut_b (set-dominant, from Q=0) also sees both high
        a_set = 1'b1; a_reset = 1'b0; step();
        check_a("set_again", 1'b1, 1'b0, 1'b1);
        a_set = 1'b1; a_reset = 1'b1;
        b_set = 1'b1; b_reset = 1'b1; step();
        check_a("both_rd1", 1'b0, 1'b1, 1'b1);
        check("both_rd0.Q",        {3'b0, b_q},    4'b0001);
        check("both_rd0.Q_n",      {3'b0, b_qn},   4'b0000);
        check("both_rd0.conflict", {3'b0, b_conf}, 4'b0001);
        check("both_rd0.changed",  {3'b0, b_chg},  4'b0001);

        // Both held high: conflict persists, no further change
        for (int i = 0; i < 3; i++) begin
            step();
            check("both_hold_rd0.Q",        {3'b0, b_q},    4'b0001);
            check("both_hold_rd0.conflict", {3'b0, b_conf}, 4'b0001);
            check("both_hold_rd0.changed",  {3'b0, b_chg},  4'b0000);
            check_a("both_hold_rd1", 1'b0, 1'b1, 1'b0);
        end
        b_set = 1'b0; b_reset = 1'b0;

        // Set while already 1 gives no change pulse
        a_set = 1'b1; a_reset = 1'b0; step();
        check_a("set_from0", 1'b1, 1'b0, 1'b1);
        step();
        check_a("set_while1", 1'b1, 1'b0, 1'b0);

        // Hold for 5 edges
        a_set = 1'b0; a_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_a("hold", 1'b1, 1'b0, 1'b0);
        end

        // Mid-cycle reset drops Q without a clock edge
        a_set = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_a("mid_rst", 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step();
        check_a("after_rst_set", 1'b1, 1'b0, 1'b1);

        // Wide bank: INIT=1010, set bit0, reset bit3
        c_set = 4'b0001; c_reset = 4'b1000; step();
        check("wide.Q",        c_q,    4'b0011);
        check("wide.changed",  c_chg,  4'b1001);
        check("wide.conflict", c_conf, 4'b0000);
        for (int i = 0; i < 4; i++)
            check($sformatf("wide.Q_n[%0d]", i), {3'b0, c_qn[i]}, {3'b0, ~c_q[i]});
        check("wide.Q_n", c_qn, 4'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_latch_sr
`default_nettype wire
